pcileech_eth_rmii_tx: RTL

- RMII transmit MAC for the Ethernet com path. It is the transmit-side counterpart of the RMII receive path that feeds UDP commands into the FIFO controller.
- Accepts a byte stream (one frame per s_tlast-terminated burst) from the UDP/IP framer. Emits preamble, SFD, data, zero-pad, CRC-32 FCS and inter-frame gap as 2-bit RMII dibits at 100 Mbit/s.
- Runs on the 50 MHz RMII reference clock, one dibit per clock.

---
 rtl/pcileech_eth_rmii_tx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pcileech_eth_rmii_tx.sv
// RMII transmit MAC: byte stream in, preamble/SFD/data/pad/FCS/IFG out as 2-bit dibits.
// Every output is registered; the next-cycle values are derived from the next-state decode.
module pcileech_eth_rmii_tx #(
  parameter int IFG_DIBITS      = 48,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic        eth_tx_en,
  output logic [1:0]  eth_tx_data,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, DROP, IFG} state_t;

  localparam logic [10:0] MIN_B    = 11'(MIN_FRAME_BYTES);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_DIBITS - 1);

  state_t      state, state_n;
  logic [7:0]  dcnt, dcnt_n;
  logic [7:0]  byte_q, byte_n;
  logic        last_q, last_n;
  logic [10:0] bcnt, bcnt_n, bcnt_inc;
  logic [31:0] crc, crc_n;
  logic        underrun_n;
  logic [15:0] frames_n;
  logic        tready_n, tx_en_n;
  logic [1:0]  txd_n, dib;

  // Reflected CRC-32 advanced by one dibit, bit 0 first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  assign dib      = byte_q[{dcnt[1:0], 1'b0} +: 2];
  assign bcnt_inc = bcnt + 11'd1;

  always_comb begin
    state_n    = state;
    dcnt_n     = dcnt;
    byte_n     = byte_q;
    last_n     = last_q;
    bcnt_n     = bcnt;
    crc_n      = crc;
    underrun_n = underrun;
    frames_n   = frames_sent;
    unique case (state)
      IDLE: if (s_tvalid) begin
        state_n = PREAMBLE;
        dcnt_n  = 8'd0;
        crc_n   = 32'hFFFF_FFFF;
        bcnt_n  = 11'd0;
      end
      PREAMBLE: if (dcnt == 8'd31) begin
        dcnt_n = 8'd0;
        if (s_tvalid) begin
          byte_n  = s_tdata;
          last_n  = s_tlast;
          bcnt_n  = 11'd1;
          state_n = DATA;
        end else begin
          state_n    = DROP;
          underrun_n = 1'b1;
        end
      end else dcnt_n = dcnt + 8'd1;
      DATA: begin
        crc_n = crc_dibit(crc, dib);
        if (dcnt[1:0] == 2'd3) begin
          dcnt_n = 8'd0;
          if (last_q) state_n = (bcnt < MIN_B) ? PAD : FCS;
          else if (s_tvalid) begin
            byte_n = s_tdata;
            last_n = s_tlast;
            bcnt_n = (bcnt == 11'h7FF) ? bcnt : bcnt_inc;
          end else begin
            state_n    = DROP;
            underrun_n = 1'b1;
          end
        end else dcnt_n = dcnt + 8'd1;
      end
      PAD: begin
        crc_n = crc_dibit(crc, 2'b00);
        if (dcnt[1:0] == 2'd3) begin
          dcnt_n = 8'd0;
          bcnt_n = bcnt_inc;
          if (bcnt_inc >= MIN_B) state_n = FCS;
        end else dcnt_n = dcnt + 8'd1;
      end
      FCS: if (dcnt == 8'd15) begin
        frames_n = frames_sent + 16'd1;
        state_n  = IFG;
        dcnt_n   = 8'd0;
      end else dcnt_n = dcnt + 8'd1;
      DROP: if (s_tvalid && s_tlast) begin
        state_n = IFG;
        dcnt_n  = 8'd0;
      end
      IFG: if (dcnt == IFG_LAST) state_n = IDLE;
           else dcnt_n = dcnt + 8'd1;
      default: state_n = IDLE;
    endcase

    tx_en_n = state_n inside {PREAMBLE, DATA, PAD, FCS};
    unique case (state_n)
      PREAMBLE: txd_n = (dcnt_n == 8'd31) ? 2'b11 : 2'b01;
      DATA:     txd_n = byte_n[{dcnt_n[1:0], 1'b0} +: 2];
      FCS:      txd_n = ~crc_n[{dcnt_n[3:0], 1'b0} +: 2];
      default:  txd_n = 2'b00;
    endcase
    // Ready only in the slot where the next byte is actually latched.
    tready_n = (state_n == PREAMBLE && dcnt_n == 8'd31) ||
               (state_n == DATA && dcnt_n[1:0] == 2'd3 && !last_n) ||
               (state_n == DROP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dcnt        <= 8'd0;
      byte_q      <= 8'd0;
      last_q      <= 1'b0;
      bcnt        <= 11'd0;
      crc         <= 32'hFFFF_FFFF;
      s_tready    <= 1'b0;
      eth_tx_en   <= 1'b0;
      eth_tx_data <= 2'b00;
      busy        <= 1'b0;
      underrun    <= 1'b0;
      frames_sent <= 16'd0;
    end else begin
      state       <= state_n;
      dcnt        <= dcnt_n;
      byte_q      <= byte_n;
      last_q      <= last_n;
      bcnt        <= bcnt_n;
      crc         <= crc_n;
      s_tready    <= tready_n;
      eth_tx_en   <= tx_en_n;
      eth_tx_data <= txd_n;
      busy        <= (state_n != IDLE);
      underrun    <= underrun_n;
      frames_sent <= frames_n;
    end
  end

endmodule
